avalon_st_packet_arbiter: RTL and testbench

- Round-robin, packet-atomic arbiter that merges NUM_SRC Avalon-ST sources onto one Avalon-ST sink.
- Sits in front of any shared Avalon-ST consumer, such as a MAC TX path or a DMA write channel.
- A grant is locked from the first beat of a packet until its eop beat is accepted.
- The data path is a zero-latency mux from the granted source. The arbitration decision is registered.

---
 rtl/avalon_st_packet_arbiter_if.sv | 20 ++
 rtl/avalon_st_packet_arbiter.sv | 118 +++++++++++
 tb/tb_avalon_st_packet_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_st_packet_arbiter_if.sv
// Avalon-ST stream bundle shared by the arbiter's sources and its sink.
// tx drives the payload and rx returns ready. master and slave are aliases of tx and rx.
interface avalon_st_if #(
  parameter int DATAW = 64
);
  localparam int EMPTYW = (DATAW > 8) ? $clog2(DATAW / 8) : 1;

  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;
  logic              error;
  logic [DATAW-1:0]  data;
  logic [EMPTYW-1:0] empty;

  modport tx     (output valid, sop, eop, error, data, empty, input ready);
  modport rx     (input valid, sop, eop, error, data, empty, output ready);
  modport master (output valid, sop, eop, error, data, empty, input ready);
  modport slave  (input valid, sop, eop, error, data, empty, output ready);
endinterface

// File: rtl/avalon_st_packet_arbiter.sv
// Round-robin Avalon-ST merger. A grant is held for a whole packet and one
// IDLE cycle is spent arbitrating between packets. The data path is a pure mux.
module avalon_st_packet_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATAW   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  avalon_st_if.rx                    src [NUM_SRC],
  avalon_st_if.tx                    snk,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       busy
);
  localparam int GW     = $clog2(NUM_SRC);
  localparam int EMPTYW = (DATAW > 8) ? $clog2(DATAW / 8) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   rr_ptr, rr_nx;
  logic [GW-1:0]   gid, gid_nx;
  logic            first_beat, fb_nx;

  logic              s_valid [NUM_SRC];
  logic              s_sop   [NUM_SRC];
  logic              s_eop   [NUM_SRC];
  logic              s_err   [NUM_SRC];
  logic [DATAW-1:0]  s_data  [NUM_SRC];
  logic [EMPTYW-1:0] s_empty [NUM_SRC];
  logic              s_ready [NUM_SRC];

  // Interface arrays cannot be indexed by a run-time value, so flatten them here.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign s_valid[i]   = src[i].valid;
    assign s_sop[i]     = src[i].sop;
    assign s_eop[i]     = src[i].eop;
    assign s_err[i]     = src[i].error;
    assign s_data[i]    = src[i].data;
    assign s_empty[i]   = src[i].empty;
    assign src[i].ready = s_ready[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gid        <= '0;
      first_beat <= 1'b1;
    end else begin
      state      <= state_nx;
      rr_ptr     <= rr_nx;
      gid        <= gid_nx;
      first_beat <= fb_nx;
    end
  end

  always_comb begin
    int unsigned idx;
    logic        found;
    logic [GW-1:0] pick;

    state_nx  = state;
    rr_nx     = rr_ptr;
    gid_nx    = gid;
    fb_nx     = first_beat;
    idx       = 0;
    found     = 1'b0;
    pick      = '0;
    snk.valid = 1'b0;
    snk.sop   = 1'b0;
    snk.eop   = 1'b0;
    snk.error = 1'b0;
    snk.data  = '0;
    snk.empty = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) s_ready[k] = 1'b0;

    unique case (state)
      IDLE: begin
        // First requester at or after rr_ptr, wrapping modulo NUM_SRC.
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
          idx = (32'(rr_ptr) + k) % NUM_SRC;
          if (!found && s_valid[GW'(idx)]) begin
            found = 1'b1;
            pick  = GW'(idx);
          end
        end
        if (found) begin
          state_nx = LOCKED;
          gid_nx   = pick;
          fb_nx    = 1'b1;
        end
      end

      LOCKED: begin
        snk.valid    = s_valid[gid];
        snk.sop      = s_sop[gid];
        snk.eop      = s_eop[gid];
        snk.data     = s_data[gid];
        snk.empty    = s_empty[gid];
        snk.error    = s_err[gid] | (first_beat & ~s_sop[gid]) | (~first_beat & s_sop[gid]);
        s_ready[gid] = snk.ready;
        if (s_valid[gid] && snk.ready) begin
          fb_nx = 1'b0;
          if (s_eop[gid]) begin
            fb_nx    = 1'b1;
            state_nx = IDLE;
            rr_nx    = (gid == GW'(NUM_SRC - 1)) ? '0 : gid + GW'(1);
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign grant_id = gid;
  assign busy     = (state == LOCKED);
endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Directed bench for the packet arbiter: a 4-source instance plus a 3-source
// instance for the modulo wrap with single-beat packets.
module tb_avalon_st_packet_arbiter;
  logic clk;
  logic rst;
  logic tb_snk_ready;
  logic [1:0] grant_id, grant3;
  logic busy, busy3;

  int vectors    = 0;
  int miscompares = 0;

  avalon_st_if #(.DATAW(64)) src_if [4] ();
  avalon_st_if #(.DATAW(64)) snk_if ();
  avalon_st_if #(.DATAW(64)) src3_if [3] ();
  avalon_st_if #(.DATAW(64)) snk3_if ();

  logic        tb_valid [4];
  logic        tb_sop   [4];
  logic        tb_eop   [4];
  logic        tb_err   [4];
  logic [63:0] tb_data  [4];
  logic [2:0]  tb_empty [4];
  logic        tb_ready [4];

  logic        t_valid [3];
  logic        t_sop   [3];
  logic        t_eop   [3];
  logic [63:0] t_data  [3];
  logic        t_ready [3];

  for (genvar g = 0; g < 4; g++) begin : g_s4
    assign src_if[g].valid = tb_valid[g];
    assign src_if[g].sop   = tb_sop[g];
    assign src_if[g].eop   = tb_eop[g];
    assign src_if[g].error = tb_err[g];
    assign src_if[g].data  = tb_data[g];
    assign src_if[g].empty = tb_empty[g];
    assign tb_ready[g]     = src_if[g].ready;
  end

  for (genvar g = 0; g < 3; g++) begin : g_s3
    assign src3_if[g].valid = t_valid[g];
    assign src3_if[g].sop   = t_sop[g];
    assign src3_if[g].eop   = t_eop[g];
    assign src3_if[g].error = 1'b0;
    assign src3_if[g].data  = t_data[g];
    assign src3_if[g].empty = '0;
    assign t_ready[g]       = src3_if[g].ready;
  end

  assign snk_if.ready  = tb_snk_ready;
  assign snk3_if.ready = 1'b1;

  avalon_st_packet_arbiter #(.NUM_SRC(4), .DATAW(64)) u_dut (
    .clk(clk), .reset(rst), .src(src_if), .snk(snk_if), .grant_id(grant_id), .busy(busy)
  );

  avalon_st_packet_arbiter #(.NUM_SRC(3), .DATAW(64)) u_dut3 (
    .clk(clk), .reset(rst), .src(src3_if), .snk(snk3_if), .grant_id(grant3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source model state: enabled sources offer back-to-back packets of len beats.
  logic en   [4];
  int   len  [4];
  int   beat [4];
  int   pkt  [4];

  function automatic logic [63:0] enc(input int s, input int p, input int b);
    return 64'hD000_0000_0000_0000 | (64'(s) << 12) | (64'(p) << 8) | 64'(b);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        tb_valid[i] = 1'b1;
        tb_sop[i]   = (beat[i] == 0);
        tb_eop[i]   = (beat[i] == len[i] - 1);
        tb_data[i]  = enc(i, pkt[i], beat[i]);
        tb_err[i]   = 1'b0;
        tb_empty[i] = tb_eop[i] ? 3'(i + 1) : 3'd0;
      end
    end
  endtask

  task automatic clk_step();
    logic x [4];
    @(negedge clk);
    for (int i = 0; i < 4; i++) x[i] = tb_valid[i] && tb_ready[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (x[i] && en[i]) begin
        beat[i]++;
        if (beat[i] == len[i]) begin
          beat[i] = 0;
          pkt[i]++;
        end
      end
    end
    refresh();
    #1;
  endtask

  task automatic all_off();
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0; tb_valid[i] = 1'b0; tb_sop[i] = 1'b0; tb_eop[i] = 1'b0;
      tb_err[i] = 1'b0; tb_empty[i] = '0; tb_data[i] = '0;
      beat[i] = 0; pkt[i] = 0; len[i] = 1;
    end
  endtask

  task automatic set0(input logic v, input logic s, input logic e, input logic er, input logic [63:0] d);
    tb_valid[0] = v; tb_sop[0] = s; tb_eop[0] = e; tb_err[0] = er; tb_data[0] = d; tb_empty[0] = '0;
  endtask

  initial begin
    int beats;
    rst = 1'b1;
    tb_snk_ready = 1'b1;
    all_off();
    for (int i = 0; i < 3; i++) begin
      t_valid[i] = 1'b0; t_sop[i] = 1'b0; t_eop[i] = 1'b0; t_data[i] = '0;
    end
    clk_step();
    clk_step();

    // Reset state.
    chk("rst_valid", snk_if.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_data", snk_if.data, 0);
    chk("rst_ready0", tb_ready[0], 0);
    chk("rst3_valid", snk3_if.valid, 0);

    // Single source: src[2], 3 beats.
    rst = 1'b0;
    en[2] = 1'b1; len[2] = 3;
    refresh(); #1;
    chk("s1_c0_valid", snk_if.valid, 0);
    chk("s1_c0_ready2", tb_ready[2], 0);
    clk_step();
    chk("s1_c1_grant", grant_id, 2);
    chk("s1_c1_busy", busy, 1);
    chk("s1_c1_sop", snk_if.sop, 1);
    chk("s1_c1_data", snk_if.data, enc(2, 0, 0));
    chk("s1_c1_ready2", tb_ready[2], 1);
    clk_step();
    chk("s1_c2_data", snk_if.data, enc(2, 0, 1));
    chk("s1_c2_sop", snk_if.sop, 0);
    chk("s1_c2_err", snk_if.error, 0);
    clk_step();
    chk("s1_c3_data", snk_if.data, enc(2, 0, 2));
    chk("s1_c3_eop", snk_if.eop, 1);
    chk("s1_c3_empty", snk_if.empty, 3);
    chk("s1_c3_busy", busy, 1);
    clk_step();
    chk("s1_c4_busy", busy, 0);
    chk("s1_c4_grant_hold", grant_id, 2);
    all_off();
    // rr_ptr is now 3: src3 must beat src0.
    en[0] = 1'b1; len[0] = 1;
    en[3] = 1'b1; len[3] = 1;
    refresh(); #1;
    chk("s1_c4_valid", snk_if.valid, 0);
    clk_step();
    chk("rr3_grant", grant_id, 3);
    chk("rr3_data", snk_if.data, enc(3, 0, 0));
    chk("rr3_ready0", tb_ready[0], 0);
    clk_step();
    chk("rr3_bubble", snk_if.valid, 0);
    clk_step();
    chk("rr0_grant", grant_id, 0);
    chk("rr0_data", snk_if.data, enc(0, 0, 0));
    clk_step();
    all_off();

    // Round robin from reset, every source offering 2-beat packets.
    rst = 1'b1; #1;
    clk_step();
    for (int i = 0; i < 4; i++) begin en[i] = 1'b1; len[i] = 2; end
    rst = 1'b0;
    refresh(); #1;
    beats = 0;
    for (int c = 0; c < 15; c++) begin
      if (c % 3 == 0) begin
        chk($sformatf("rr_c%0d_bubble", c), snk_if.valid, 0);
      end else begin
        chk($sformatf("rr_c%0d_grant", c), grant_id, ((c - 1) / 3) % 4);
        chk($sformatf("rr_c%0d_data", c), snk_if.data,
            enc(((c - 1) / 3) % 4, (c >= 13) ? 1 : 0, (c - 1) % 3));
        chk($sformatf("rr_c%0d_eop", c), snk_if.eop, ((c - 1) % 3 == 1) ? 1 : 0);
      end
      if (c < 12 && snk_if.valid && snk_if.ready) beats++;
      if (c == 11) chk("rr_beats_in_12", beats, 8);
      clk_step();
    end
    all_off();

    // Backpressure on src[1] (rr_ptr = 1), src[0] also requesting.
    en[1] = 1'b1; len[1] = 4;
    en[0] = 1'b1; len[0] = 2;
    refresh(); #1;
    clk_step();
    chk("bp_grant", grant_id, 1);
    chk("bp_b0", snk_if.data, enc(1, 0, 0));
    clk_step();
    chk("bp_b1", snk_if.data, enc(1, 0, 1));
    tb_snk_ready = 1'b0; #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("bp_stall%0d_ready1", s), tb_ready[1], 0);
      chk($sformatf("bp_stall%0d_ready0", s), tb_ready[0], 0);
      chk($sformatf("bp_stall%0d_data", s), snk_if.data, enc(1, 0, 1));
      chk($sformatf("bp_stall%0d_valid", s), snk_if.valid, 1);
      if (s < 2) clk_step();
    end
    tb_snk_ready = 1'b1; #1;
    chk("bp_resume_ready1", tb_ready[1], 1);
    clk_step();
    chk("bp_b2", snk_if.data, enc(1, 0, 2));
    clk_step();
    chk("bp_b3", snk_if.data, enc(1, 0, 3));
    chk("bp_b3_eop", snk_if.eop, 1);
    clk_step();
    chk("bp_bubble", snk_if.valid, 0);
    chk("bp_pkts_src1", pkt[1], 1);
    clk_step();
    chk("bp_next_grant", grant_id, 0);
    chk("bp_next_data", snk_if.data, enc(0, 0, 0));
    clk_step();
    clk_step();
    all_off();

    // Protocol errors on src[0] (rr_ptr = 1, only src0 requesting).
    set0(1, 0, 0, 0, 64'hE0); #1;
    clk_step();
    chk("pe1_grant", grant_id, 0);
    chk("pe1_sop", snk_if.sop, 0);
    chk("pe1_data", snk_if.data, 64'hE0);
    chk("pe1_err", snk_if.error, 1);
    clk_step();
    set0(1, 0, 1, 0, 64'hE1); #1;
    chk("pe1_b1_err", snk_if.error, 0);
    chk("pe1_b1_eop", snk_if.eop, 1);
    clk_step();
    chk("pe1_release", busy, 0);
    set0(1, 1, 0, 0, 64'hE2); #1;
    clk_step();
    chk("pe2_b0_err", snk_if.error, 0);
    clk_step();
    set0(1, 1, 0, 0, 64'hE3); #1;
    chk("pe2_b1_err", snk_if.error, 1);
    chk("pe2_b1_data", snk_if.data, 64'hE3);
    clk_step();
    set0(1, 0, 1, 1, 64'hE4); #1;
    chk("pe2_b2_srcerr", snk_if.error, 1);
    clk_step();
    chk("pe2_release", busy, 0);
    all_off(); #1;

    // Reset during beat 2 of 4 from src[3].
    en[3] = 1'b1; len[3] = 4;
    refresh(); #1;
    clk_step();
    chk("rm_grant", grant_id, 3);
    clk_step();
    chk("rm_b1_data", snk_if.data, enc(3, 0, 1));
    rst = 1'b1; #1;
    chk("rm_valid_drop", snk_if.valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_grant_rst", grant_id, 0);
    beat[3] = 0;
    en[0] = 1'b1; len[0] = 2;
    refresh();
    clk_step();
    rst = 1'b0; #1;
    chk("rm_idle_valid", snk_if.valid, 0);
    clk_step();
    chk("rm_rearb_grant", grant_id, 0);
    chk("rm_rearb_data", snk_if.data, enc(0, 0, 0));
    chk("rm_rearb_ready3", tb_ready[3], 0);
    clk_step();
    clk_step();
    all_off();

    // NUM_SRC=3: bring rr_ptr to 2, then single-beat packets from src2 and src0.
    t_valid[1] = 1'b1; t_sop[1] = 1'b1; t_eop[1] = 1'b1; t_data[1] = 64'hF1; #1;
    chk("w_c0_valid", snk3_if.valid, 0);
    clk_step();
    chk("w_pre_grant", grant3, 1);
    clk_step();
    t_valid[1] = 1'b0;
    t_valid[2] = 1'b1; t_sop[2] = 1'b1; t_eop[2] = 1'b1; t_data[2] = 64'hF2;
    t_valid[0] = 1'b1; t_sop[0] = 1'b1; t_eop[0] = 1'b1; t_data[0] = 64'hF0; #1;
    chk("w_bubble0", snk3_if.valid, 0);
    clk_step();
    chk("w_grant2", grant3, 2);
    chk("w_data2", snk3_if.data, 64'hF2);
    chk("w_ready0_held", t_ready[0], 0);
    clk_step();
    t_valid[2] = 1'b0; #1;
    chk("w_bubble1", snk3_if.valid, 0);
    chk("w_busy_idle", busy3, 0);
    clk_step();
    chk("w_grant0", grant3, 0);
    chk("w_data0", snk3_if.data, 64'hF0);
    chk("w_eop0", snk3_if.eop, 1);
    clk_step();
    t_valid[0] = 1'b0; #1;
    chk("w_done_valid", snk3_if.valid, 0);
    chk("w_done_grant", grant3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
